// File: rtl/bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_alu_seq
// Description : Multi-cycle bit-serial ALU sequencer. Accepts a full-width
//               operand pair and a 3-bit op, processes DIGIT bits per cycle
//               LSB first with a registered carry, and returns the assembled
//               result plus flags over a valid/ready handshake.
//
//   Op codes : 000 B | 001 0 | 010 A+B | 011 A-B (A+~B+1)
//              100 A&B | 101 A|B | 110 A^B | 111 0
//
//   Ports    : clk, reset (async, active-high)
//              in_valid/in_ready, in_a, in_b, in_op      - request side
//              out_valid/out_ready, out_result, out_zero,
//              out_neg, out_carry, out_ovf               - result side
//
//   Parameters : WIDTH (operand width), DIGIT (bits per cycle: 1,2,4,8,16)
//
//   Optional   : BIT_SERIAL_ALU_SHORTCUT_EN - ops 000/001/111 bypass the
//                serial walk and complete on the accept edge.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_alu_seq #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int c_NUM_DIGITS = WIDTH / DIGIT;
  localparam int c_CNT_W      = $clog2(c_NUM_DIGITS) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(c_NUM_DIGITS - 1);

  localparam logic [2:0] c_OP_PASSB = 3'b000;
  localparam logic [2:0] c_OP_ZERO0 = 3'b001;
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_SUB   = 3'b011;
  localparam logic [2:0] c_OP_AND   = 3'b100;
  localparam logic [2:0] c_OP_OR    = 3'b101;
  localparam logic [2:0] c_OP_XOR   = 3'b110;
  localparam logic [2:0] c_OP_ZERO1 = 3'b111;

  // Reject illegal configurations at elaboration time.
  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 || DIGIT == 16)
        || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("bit_serial_alu_seq: DIGIT must be 1,2,4,8,16 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_in_ready;

  // --------------------------------------------------------------------------
  // Digit slice: operates on the low DIGIT bits of the A/B shift registers.
  // --------------------------------------------------------------------------
  logic [DIGIT-1:0]     w_ad;
  logic [DIGIT-1:0]     w_bd;
  logic [DIGIT-1:0]     w_bx;
  logic [DIGIT:0]       w_sum;
  logic [DIGIT-1:0]     w_dres;
  logic                 w_arith;
  logic                 w_cin_msb;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]     w_res_next;
  logic                 w_short;

  assign w_ad    = r_a[DIGIT-1:0];
  assign w_bd    = r_b[DIGIT-1:0];
  assign w_arith = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
  // Subtraction is A + ~B with the carry register preloaded to 1.
  assign w_bx    = (r_op == c_OP_SUB) ? ~w_bd : w_bd;
  assign w_sum   = {1'b0, w_ad} + {1'b0, w_bx} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of the digit, recovered from its sum bit.
  assign w_cin_msb = w_ad[DIGIT-1] ^ w_bx[DIGIT-1] ^ w_sum[DIGIT-1];

  always_comb begin
    w_dres = '0;
    case (r_op)
      c_OP_PASSB: w_dres = w_bd;
      c_OP_ADD,
      c_OP_SUB:   w_dres = w_sum[DIGIT-1:0];
      c_OP_AND:   w_dres = w_ad & w_bd;
      c_OP_OR:    w_dres = w_ad | w_bd;
      c_OP_XOR:   w_dres = w_ad ^ w_bd;
      default:    w_dres = '0;
    endcase
  end

  // New digit enters at the MSB end; after all digits the LSB digit has
  // travelled down to bit 0. The concatenation keeps the slice legal even
  // when WIDTH == DIGIT.
  assign w_res_cat  = {w_dres, r_res};
  assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef BIT_SERIAL_ALU_SHORTCUT_EN
  assign w_short = (in_op == c_OP_PASSB) || (in_op == c_OP_ZERO0) ||
                   (in_op == c_OP_ZERO1);
`else
  assign w_short = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            if (w_short) begin
              // Pass-B and constant-zero ops need no serial walk.
              r_res       <= (in_op == c_OP_PASSB) ? in_b : '0;
              r_zero      <= (in_op == c_OP_PASSB) ? (in_b == '0) : 1'b1;
              r_neg       <= (in_op == c_OP_PASSB) ? in_b[WIDTH-1] : 1'b0;
              r_carry     <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_a     <= in_a;
              r_b     <= in_b;
              r_op    <= in_op;
              r_carry <= (in_op == c_OP_SUB);
              r_zero  <= 1'b0;
              r_neg   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= w_res_next;
          r_cnt <= r_cnt + c_CNT_W'(1);
          // Logic/pass ops leave the carry at its preload value (0).
          if (w_arith) begin
            r_carry <= w_sum[DIGIT];
          end
          if (r_cnt == c_LAST_DIGIT) begin
            r_ovf       <= w_arith ? (w_cin_msb ^ w_sum[DIGIT]) : 1'b0;
            r_zero      <= (w_res_next == '0);
            r_neg       <= w_res_next[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          // Return to IDLE first; a new request is taken the next cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_res;
  assign out_zero   = r_zero;
  assign out_neg    = r_neg;
  assign out_carry  = r_carry;
  assign out_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_alu_seq
// Description : Directed self-checking bench for bit_serial_alu_seq. Two
//               instances (DIGIT=1 and DIGIT=8, WIDTH=64) share the operand
//               inputs; 'sel' chooses which one a step talks to.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv;
  logic        sel;
  logic [63:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_ready;

  logic        iv1, iv8;
  logic        rdy1, rdy8, ov1, ov8;
  logic [63:0] res1, res8;
  logic        z1, z8, n1, n8, c1, c8, o1, o8;

  logic        m_ready, m_valid, m_zero, m_neg, m_carry, m_ovf;
  logic [63:0] m_res;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign iv1 = iv & ~sel;
  assign iv8 = iv & sel;

  assign m_ready = sel ? rdy8 : rdy1;
  assign m_valid = sel ? ov8  : ov1;
  assign m_res   = sel ? res8 : res1;
  assign m_zero  = sel ? z8   : z1;
  assign m_neg   = sel ? n8   : n1;
  assign m_carry = sel ? c8   : c1;
  assign m_ovf   = sel ? o8   : o1;

  bit_serial_alu_seq #(.WIDTH(64), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset),
    .in_valid(iv1), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_zero(z1), .out_neg(n1),
    .out_carry(c1), .out_ovf(o1)
  );

  bit_serial_alu_seq #(.WIDTH(64), .DIGIT(8)) u_d8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(rdy8),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(ov8), .out_ready(out_ready),
    .out_result(res8), .out_zero(z8), .out_neg(n8),
    .out_carry(c8), .out_ovf(o8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected accept-to-valid latency, counting the cycle after the accept
  // edge as cycle 1.
  function automatic int exp_lat(input logic s, input logic [2:0] op);
`ifdef BIT_SERIAL_ALU_SHORTCUT_EN
    if (op == 3'b000 || op == 3'b001 || op == 3'b111) return 1;
`endif
    return s ? 9 : 65;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!m_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic [63:0] er,
                        input logic ez, input logic en, input logic ec,
                        input logic eo, input string tag);
    int t;
    int lat;
    sel = s; in_a = a; in_b = b; in_op = op;
    t = 0;
    while (!m_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, " in_ready"}, 64'(m_ready), 64'd1);
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    // Inputs change after accept; must not affect the result.
    in_a = ~a; in_b = ~b; in_op = ~op;
    wait_valid(lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(s, op)));
    chk({tag, " result"},  m_res, er);
    chk({tag, " zero"},    64'(m_zero),  64'(ez));
    chk({tag, " neg"},     64'(m_neg),   64'(en));
    chk({tag, " carry"},   64'(m_carry), 64'(ec));
    chk({tag, " ovf"},     64'(m_ovf),   64'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    reset = 1'b1; iv = 1'b0; sel = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("reset in_ready", 64'(m_ready), 64'd1);
      chk("reset out_valid", 64'(m_valid), 64'd0);
      chk("reset result", m_res, 64'd0);
      chk("reset flags", {60'd0, m_zero, m_neg, m_carry, m_ovf}, 64'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Arithmetic, DIGIT=1
    run_op(0, 64'd5, 64'd3, 3'b010, 64'd8, 0, 0, 0, 0, "add 5+3");
    run_op(0, 64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, "sub 3-5");
    run_op(0, 64'd7, 64'd7, 3'b011, 64'd0, 1, 0, 1, 0, "sub 7-7");
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000,
           0, 1, 0, 1, "add ovf");
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010,
           64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 0, "add ones");

    // Logic ops on both widths
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b100, 64'hF000, 0, 0, 0, 0, "and");
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b101, 64'hFFF0, 0, 0, 0, 0, "or");
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b110, 64'h0FF0, 0, 0, 0, 0, "xor");
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b000, 64'hFF00, 0, 0, 0, 0, "passb");
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b111, 64'd0, 1, 0, 0, 0, "zero111");
      run_op(s[0], 64'hF0F0, 64'hFF00, 3'b001, 64'd0, 1, 0, 0, 0, "zero001");
    end

    // Arithmetic across digit boundaries with DIGIT=8
    run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000,
           0, 1, 0, 1, "d8 add ovf");
    run_op(1, 64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, "d8 sub");
    run_op(1, 64'h0000_0000_0001_00FF, 64'h0000_0000_0000_0001, 3'b010,
           64'h0000_0000_0001_0100, 0, 0, 0, 0, "d8 add carry chain");

    // Backpressure on DIGIT=8 with a queued request
    sel = 1'b1; in_a = 64'd5; in_b = 64'd3; in_op = 3'b010;
    iv = 1'b1;
    @(posedge clk); #1;
    in_a = 64'd2; in_b = 64'd3; in_op = 3'b100;   // queued request, held
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'd9);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 64'(m_valid), 64'd1);
      chk("bp hold result", m_res, 64'd8);
      chk("bp hold in_ready", 64'(m_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp after hs valid", 64'(m_valid), 64'd0);
    chk("bp after hs in_ready", 64'(m_ready), 64'd1);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("bp queued accepted", 64'(m_ready), 64'd0);
    wait_valid(lat);
    chk("bp queued latency", 64'(lat), 64'd9);
    chk("bp queued result", m_res, 64'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of RUN on DIGIT=1
    sel = 1'b0; in_a = 64'd5; in_b = 64'd3; in_op = 3'b010;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("mid-run reset in_ready", 64'(m_ready), 64'd1);
    chk("mid-run reset valid", 64'(m_valid), 64'd0);
    chk("mid-run reset result", m_res, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1'b1;
    end
    chk("dropped op no output", 64'(seen), 64'd0);
    chk("in_ready after reset", 64'(m_ready), 64'd1);
    run_op(0, 64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0, "post-reset add");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Multi-cycle sequencer that drives the bit-slice ALU control interface from the issuing side.
- Accepts a full-width operand pair plus a 3-bit ALU op, then walks DIGIT bits per cycle through slice logic, LSB first. The carry is registered between cycles.
- Returns the assembled result and flags to the execute stage over a valid/ready handshake.
- Used where area matters more than latency (e.g. the multiplier/divider helper path).

Parameters:
- WIDTH, 64, operand/result width in bits.
- DIGIT, 1, bits processed per cycle. Legal values are 1, 2, 4, 8, 16. WIDTH % DIGIT must be 0; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  ALU op code.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  result word.
- out_zero  output  1  result == 0.
- out_neg  output  1  result[WIDTH-1].
- out_carry  output  1  final carry-out (add/sub only, else 0).
- out_ovf  output  1  signed overflow (add/sub only, else 0).

Behaviour:
- Op encoding (per bit i):
  - 000: B[i].
  - 001: 0.
  - 010: A+B with carry chain.
  - 011: A+~B, chain starts with carry 1.
  - 100: A&B.
  - 101: A|B.
  - 110: A^B.
  - 111: 0.
- Logical and pass ops ignore the carry. Carry-in for op 010 is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A, B and op into shift registers; set carry to op==011; set digit counter to 0; go to RUN.
- RUN:
  - Each cycle: compute DIGIT result bits from the low DIGIT bits of the A/B shift regs and the carry register.
  - Shift the result in at the MSB end of the result register. Shift A/B right by DIGIT. Update the carry register. Increment the counter.
  - After WIDTH/DIGIT RUN cycles, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; outputs hold stable until out_valid&out_ready.
  - On handshake, return to IDLE.
  - DONE→IDLE then accept a new request; no same-cycle pass-through. out_valid is therefore never high in the cycle after a handshake.
- Latency: WIDTH/DIGIT+1 cycles from the accept edge to out_valid high (64 cycles RUN plus 1 for DIGIT=1 default).
- Throughput: one op per WIDTH/DIGIT+2 cycles with out_ready held high.
- Flags:
  - out_carry = carry register after the last digit.
  - out_ovf = carry into MSB XOR carry out of MSB. Captured during the final digit.
  - out_zero and out_neg are computed from the final out_result register (registered, valid with out_valid).
- Inputs in_a/in_b/in_op are sampled only on the accept edge. Later changes have no effect.
- in_valid while busy is ignored (in_ready=0). The requester must hold the request.
- Reset at any time, including mid-RUN or DONE:
  - State=IDLE; in_ready=1 after reset deasserts.
  - out_valid=0; out_result=0; all flags=0; carry/counter=0.
  - Any in-flight op is dropped with no output.
- Counter width is $clog2(WIDTH/DIGIT)+1. No wrap occurs because RUN exits at terminal count.

Optional Feature:
- Macro: BIT_SERIAL_ALU_SHORTCUT_EN.
- Defined:
  - Ops 000, 001 and 111 skip RUN. The accept edge writes out_result directly (B, 0, 0 respectively) plus flags, and goes straight to DONE.
  - out_valid is high the cycle after accept.
  - Carry/ovf=0.
- Undefined: all ops take the full RUN sequence. Results are bit-identical either way; only latency differs.

Test Plan:
- DIGIT=1: A=5, B=3, op=010 → out_result=8, zero=0, neg=0, carry=0, ovf=0. out_valid rises exactly 65 cycles after the accept edge.
- op=011, A=3, B=5 → result=0xFFFF_FFFF_FFFF_FFFE, neg=1, carry=0. Then A=B=0x7 → result=0, zero=1, carry=1.
- op=010, A=0x7FFF_FFFF_FFFF_FFFF, B=1 → result=0x8000_0000_0000_0000, ovf=1, neg=1. A=B=0xFFFF_FFFF_FFFF_FFFF → result=...FE, carry=1, ovf=0.
- Logic ops A=0xF0F0, B=0xFF00:
  - op 100 → 0xF000.
  - op 101 → 0xFFF0.
  - op 110 → 0x0FF0.
  - op 000 → 0xFF00.
  - op 111 → 0, zero=1.
  - Repeat all with DIGIT=8 and check latency 9 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0. Assert out_ready → IDLE next cycle; a queued in_valid is accepted the following cycle.
- Assert reset at RUN cycle 20 → out_valid stays 0, in_ready=1 after release. A new op (A=1, B=1, op=010) then returns 2. With BIT_SERIAL_ALU_SHORTCUT_EN, op=001 gives out_valid one cycle after accept.
